// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, PS/2 reply codes and helpers for the command arbiter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        TX_CMD,
        RESP_CMD,
        SEND_ARG,
        TX_ARG,
        RESP_ARG,
        DONE
    } ps2_state_t;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam int         NUM_REQ    = 3;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[2]) return 2'd2;
        if (oh[1]) return 2'd1;
        return 2'd0;
    endfunction

endpackage

// File: rtl/ps2_command_arbiter_if.sv
// rtl/ps2_command_arbiter_if.sv - requester, protocol-layer and completion signals of the arbiter
interface ps2_command_arbiter_if;

    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [2:0][7:0] req_cmd;
    logic [2:0][7:0] req_arg;
    logic [2:0]      req_has_arg;

    logic            command_valid;
    logic            command_ready;
    logic [7:0]      command_byte;

    logic            command_ack_valid;
    logic            command_ack_ready;
    logic            command_ack_error;

    logic            response_valid;
    logic [7:0]      response_byte;

    logic            done_valid;
    logic            done_error;
    logic [1:0]      done_id;
    logic            busy;

    modport master (
        input  req_valid, req_cmd, req_arg, req_has_arg,
        input  command_ready, command_ack_valid, command_ack_error,
        input  response_valid, response_byte,
        output req_ready, command_valid, command_byte, command_ack_ready,
        output done_valid, done_error, done_id, busy
    );

    modport slave (
        output req_valid, req_cmd, req_arg, req_has_arg,
        output command_ready, command_ack_valid, command_ack_error,
        output response_valid, response_byte,
        input  req_ready, command_valid, command_byte, command_ack_ready,
        input  done_valid, done_error, done_id, busy
    );

endinterface

// File: rtl/ps2_round_robin.sv
// rtl/ps2_round_robin.sv - combinational 3-way round-robin pick starting after last_grant
module ps2_round_robin (
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] grant
);

    function automatic logic [2:0] first_of(input logic [2:0] r,
                                            input logic [1:0] a,
                                            input logic [1:0] b,
                                            input logic [1:0] c);
        if (r[a]) return 3'b001 << a;
        if (r[b]) return 3'b001 << b;
        if (r[c]) return 3'b001 << c;
        return 3'b000;
    endfunction

    always_comb begin
        case (last_grant)
            2'd0:    grant = first_of(req, 2'd1, 2'd2, 2'd0);
            2'd1:    grant = first_of(req, 2'd2, 2'd0, 2'd1);
            default: grant = first_of(req, 2'd0, 2'd1, 2'd2);
        endcase
    end

endmodule

// File: rtl/ps2_command_arbiter.sv
// rtl/ps2_command_arbiter.sv - serialises keyboard commands from three requesters with resend/timeout retries
module ps2_command_arbiter
    import ps2_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_command_arbiter_if.master io
);

    ps2_state_t  state;
    ps2_state_t  retry_state;
    logic [1:0]  last_grant;
    logic [1:0]  cur_id;
    logic [1:0]  retries;
    logic [7:0]  cur_cmd;
    logic [7:0]  cur_arg;
    logic        cur_has_arg;
    logic        cur_err;
    logic [23:0] timer;
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic        in_tx;
    logic        in_resp;
    logic        cmd_phase;
    logic        resp_ack;
    logic        resp_fail;
    logic        retry_event;
    logic        can_retry;

    ps2_round_robin u_rr (
        .req        (io.req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_idx = onehot_to_idx(grant);
    assign in_tx     = (state == TX_CMD) || (state == TX_ARG);
    assign in_resp   = (state == RESP_CMD) || (state == RESP_ARG);
    assign cmd_phase = (state == SEND_CMD) || (state == TX_CMD) || (state == RESP_CMD);
    assign resp_ack  = io.response_valid && (io.response_byte == PS2_ACK);
    // An ACK arriving on the timeout cycle wins over the timeout.
    assign resp_fail = (io.response_valid && (io.response_byte == PS2_RESEND)) ||
                       (timer == TIMEOUT_CYCLES - 24'd1);
    assign retry_event = (in_tx && io.command_ack_valid && io.command_ack_error) ||
                         (in_resp && !resp_ack && resp_fail);
    assign can_retry   = retries < MAX_RETRIES;
    assign retry_state = !can_retry ? DONE : (cmd_phase ? SEND_CMD : SEND_ARG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 2'd2;
            cur_id      <= 2'd0;
            retries     <= 2'd0;
            cur_cmd     <= 8'd0;
            cur_arg     <= 8'd0;
            cur_has_arg <= 1'b0;
            cur_err     <= 1'b0;
            timer       <= 24'd0;
        end else if (retry_event) begin
            state   <= retry_state;
            retries <= can_retry ? retries + 2'd1 : retries;
            cur_err <= !can_retry;
        end else begin
            case (state)
                IDLE: begin
                    if (|io.req_valid) begin
                        cur_cmd     <= io.req_cmd[grant_idx];
                        cur_arg     <= io.req_arg[grant_idx];
                        cur_has_arg <= io.req_has_arg[grant_idx];
                        cur_id      <= grant_idx;
                        retries     <= 2'd0;
                        cur_err     <= 1'b0;
                        state       <= SEND_CMD;
                    end
                end
                SEND_CMD: if (io.command_ready) state <= TX_CMD;
                SEND_ARG: if (io.command_ready) state <= TX_ARG;
                TX_CMD: begin
                    if (io.command_ack_valid) begin
                        timer <= 24'd0;
                        state <= RESP_CMD;
                    end
                end
                TX_ARG: begin
                    if (io.command_ack_valid) begin
                        timer <= 24'd0;
                        state <= RESP_ARG;
                    end
                end
                RESP_CMD: begin
                    timer <= timer + 24'd1;
                    if (resp_ack) begin
                        retries <= 2'd0;
                        state   <= cur_has_arg ? SEND_ARG : DONE;
                    end
                end
                RESP_ARG: begin
                    timer <= timer + 24'd1;
                    if (resp_ack) state <= DONE;
                end
                DONE: begin
                    last_grant <= cur_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake strobes decode straight from the state register.
    assign io.req_ready         = ((state == IDLE) && !reset) ? grant : 3'b000;
    assign io.command_valid     = (state == SEND_CMD) || (state == SEND_ARG);
    assign io.command_byte      = (state == SEND_ARG) ? cur_arg : cur_cmd;
    assign io.command_ack_ready = in_tx;
    assign io.done_valid        = (state == DONE);
    assign io.done_error        = (state == DONE) && cur_err;
    assign io.done_id           = (state == DONE) ? cur_id : 2'd0;
    assign io.busy              = (state != IDLE);

endmodule

// File: tb/tb_ps2_command_arbiter.sv
// tb/tb_ps2_command_arbiter.sv - self-checking bench: vector table, corner sequences, randomized traffic
module tb_ps2_command_arbiter;
    import ps2_pkg::*;

    localparam logic [2:0] A_FA = 3'd0, A_FE = 3'd1, A_SIL = 3'd2, A_AERR = 3'd3,
                           A_JUNK = 3'd4, A_TFA = 3'd5, A_LFA = 3'd6;

    typedef logic [3:0][2:0] plan_t;
    typedef struct {
        logic [1:0] id;
        logic [7:0] cmd;
        logic [7:0] arg;
        bit         has_arg;
        plan_t      pc;
        plan_t      pa;
        bit         exp_err;
        int         exp_sends;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_command_arbiter_if ifc ();

    ps2_command_arbiter #(
        .TIMEOUT_CYCLES (24'd16),
        .MAX_RETRIES    (2'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (ifc)
    );

    int checks = 0;
    int failures = 0;
    int mon_bad = 0;

    always @(negedge clk)
        if ((ifc.busy && |ifc.req_ready) || !$onehot0(ifc.req_ready)) mon_bad++;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic plan_t mk(input logic [2:0] a0, input logic [2:0] a1,
                                 input logic [2:0] a2, input logic [2:0] a3);
        plan_t p;
        p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3;
        return p;
    endfunction

    // A byte succeeds on its first ACK-terminated attempt; four failures end in error.
    function automatic int phase_sends(input plan_t p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (p[i] == A_FA || p[i] == A_JUNK || p[i] == A_TFA) begin
                ok = 1'b1;
                return i + 1;
            end
        end
        return 4;
    endfunction

    function automatic logic [2:0] rnd_act(input bit last);
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 3) return A_FA;
        if (r == 4) return A_FE;
        if (r == 5) return A_SIL;
        if (r == 6) return A_AERR;
        if (r == 7) return A_JUNK;
        if (r == 8) return A_TFA;
        return last ? A_FA : A_LFA;
    endfunction

    task automatic set_req(input int id, input logic [7:0] cmd, input logic [7:0] arg, input bit has);
        ifc.req_cmd[id]     = cmd;
        ifc.req_arg[id]     = arg;
        ifc.req_has_arg[id] = has;
    endtask

    task automatic wait_cmd(input logic [7:0] exp, input string name, output bit found);
        int n = 0;
        bit stable = 1'b1;
        int h;
        while (!ifc.command_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        found = ifc.command_valid;
        if (found) begin
            h = int'($urandom_range(0, 2));
            repeat (h) begin
                @(negedge clk);
                if (!ifc.command_valid || ifc.command_byte != exp) stable = 1'b0;
            end
        end
        check(found && stable && ifc.command_byte == exp, {name, " cmd_byte"},
              32'({found, stable, ifc.command_byte}), 32'({2'b11, exp}));
        if (found) begin
            ifc.command_ready = 1'b1;
            @(negedge clk);
            ifc.command_ready = 1'b0;
        end
    endtask

    task automatic do_ack(input bit err);
        int n = 0;
        while (!ifc.command_ack_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(ifc.command_ack_ready, "ack_ready", 32'(ifc.command_ack_ready), 32'd1);
        ifc.command_ack_valid = 1'b1;
        ifc.command_ack_error = err;
        @(negedge clk);
        ifc.command_ack_valid = 1'b0;
        ifc.command_ack_error = 1'b0;
    endtask

    task automatic send_resp(input logic [7:0] b);
        ifc.response_valid = 1'b1;
        ifc.response_byte  = b;
        @(negedge clk);
        ifc.response_valid = 1'b0;
        ifc.response_byte  = 8'h00;
    endtask

    task automatic perform(input logic [2:0] a);
        if (a == A_AERR) begin
            do_ack(1'b1);
        end else begin
            do_ack(1'b0);
            case (a)
                A_FA:   send_resp(8'hFA);
                A_FE:   send_resp(8'hFE);
                A_JUNK: begin send_resp(8'h55); send_resp(8'hFA); end
                A_TFA:  begin repeat (15) @(negedge clk); send_resp(8'hFA); end
                A_LFA:  begin repeat (16) @(negedge clk); send_resp(8'hFA); end
                default: ;
            endcase
        end
    endtask

    task automatic wait_done(input logic [1:0] exp_id, input bit exp_err, input string name);
        int n = 0;
        bit extra = 1'b0;
        while (!ifc.done_valid && n < 200) begin
            if (ifc.command_valid) extra = 1'b1;
            @(negedge clk);
            n++;
        end
        check(ifc.done_valid && !extra, {name, " done"}, 32'({extra, ifc.done_valid}), 32'd1);
        check(ifc.done_id == exp_id, {name, " done_id"}, 32'(ifc.done_id), 32'(exp_id));
        check(ifc.done_error == exp_err, {name, " done_error"}, 32'(ifc.done_error), 32'(exp_err));
        @(negedge clk);
        check(!ifc.done_valid && !ifc.busy, {name, " done_pulse"}, 32'({ifc.done_valid, ifc.busy}), 32'd0);
    endtask

    task automatic service(input logic [7:0] cmd, input logic [7:0] arg, input bit has_arg,
                           input plan_t pc, input plan_t pa, input logic [1:0] exp_id,
                           input bit exp_err, input int exp_sends, input string name);
        bit okc, oka, f;
        int nc, na;
        int seen = 0;
        nc = phase_sends(pc, okc);
        for (int i = 0; i < nc; i++) begin
            wait_cmd(cmd, name, f);
            if (f) seen++;
            perform(pc[i]);
        end
        if (has_arg && okc) begin
            na = phase_sends(pa, oka);
            for (int i = 0; i < na; i++) begin
                wait_cmd(arg, name, f);
                if (f) seen++;
                perform(pa[i]);
            end
        end
        check(seen == exp_sends, {name, " sends"}, 32'(seen), 32'(exp_sends));
        wait_done(exp_id, exp_err, name);
    endtask

    task automatic grant(input logic [2:0] mask, input bit drop, input logic [1:0] exp_g, input string name);
        int n = 0;
        ifc.req_valid = mask;
        #1;
        while (ifc.req_ready == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(ifc.req_ready == (3'b001 << exp_g), {name, " grant"}, 32'(ifc.req_ready), 32'(3'b001 << exp_g));
        @(negedge clk);
        check(ifc.req_ready == 3'b000 && ifc.busy, {name, " ready_once"}, 32'({ifc.req_ready, ifc.busy}), 32'd1);
        if (drop) ifc.req_valid = 3'b000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs [8];
    plan_t all_fa;
    logic [7:0] rc [3];
    logic [7:0] ra [3];
    bit rh [3];

    initial begin
        bit f, okc, oka, acc;
        int nc, na, sends;
        logic [1:0] last, expg;
        logic [2:0] mask;
        plan_t pc, pa;

        all_fa = mk(A_FA, A_FA, A_FA, A_FA);
        vecs[0] = '{2'd1, 8'hED, 8'h02, 1'b1, mk(A_FA, A_FA, A_FA, A_FA), mk(A_FA, A_FA, A_FA, A_FA), 1'b0, 2};
        vecs[1] = '{2'd2, 8'hF4, 8'h00, 1'b0, mk(A_FE, A_FE, A_FA, A_FA), all_fa, 1'b0, 3};
        vecs[2] = '{2'd0, 8'hFF, 8'h00, 1'b0, mk(A_SIL, A_SIL, A_SIL, A_SIL), all_fa, 1'b1, 4};
        vecs[3] = '{2'd0, 8'hAB, 8'hCD, 1'b1, all_fa, mk(A_AERR, A_FA, A_FA, A_FA), 1'b0, 3};
        vecs[4] = '{2'd1, 8'h12, 8'h00, 1'b0, mk(A_TFA, A_FA, A_FA, A_FA), all_fa, 1'b0, 1};
        vecs[5] = '{2'd2, 8'h34, 8'h00, 1'b0, mk(A_LFA, A_FA, A_FA, A_FA), all_fa, 1'b0, 2};
        vecs[6] = '{2'd1, 8'h55, 8'h66, 1'b1, mk(A_AERR, A_FA, A_FA, A_FA),
                    mk(A_FE, A_AERR, A_SIL, A_FE), 1'b1, 6};
        vecs[7] = '{2'd0, 8'h77, 8'h00, 1'b0, mk(A_JUNK, A_FA, A_FA, A_FA), all_fa, 1'b0, 1};

        reset = 1'b1;
        ifc.req_valid = 3'b000;
        ifc.req_cmd = '0;
        ifc.req_arg = '0;
        ifc.req_has_arg = 3'b000;
        ifc.command_ready = 1'b0;
        ifc.command_ack_valid = 1'b0;
        ifc.command_ack_error = 1'b0;
        ifc.response_valid = 1'b0;
        ifc.response_byte = 8'h00;
        repeat (3) @(negedge clk);
        ifc.req_valid = 3'b111;
        #1;
        check(ifc.req_ready == 3'b000, "rst req_ready", 32'(ifc.req_ready), 32'd0);
        ifc.req_valid = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check(!ifc.busy, "rst busy", 32'(ifc.busy), 32'd0);
        check(!ifc.command_valid && !ifc.command_ack_ready, "rst cmd", 32'({ifc.command_valid, ifc.command_ack_ready}), 32'd0);
        check(!ifc.done_valid && !ifc.done_error && ifc.done_id == 2'd0, "rst done",
              32'({ifc.done_valid, ifc.done_error, ifc.done_id}), 32'd0);

        for (int i = 0; i < 3; i++) set_req(i, 8'hA0 + 8'(i), 8'h00, 1'b0);
        grant(3'b101, 1'b1, 2'd0, "arb101_a");
        service(8'hA0, 8'h00, 1'b0, all_fa, all_fa, 2'd0, 1'b0, 1, "arb101_a");
        grant(3'b101, 1'b1, 2'd2, "arb101_b");
        service(8'hA2, 8'h00, 1'b0, all_fa, all_fa, 2'd2, 1'b0, 1, "arb101_b");

        do_reset();
        for (int k = 0; k < 4; k++) begin
            expg = 2'(k % 3);
            grant(3'b111, k == 3, expg, "arb111");
            service(8'hA0 + 8'(expg), 8'h00, 1'b0, all_fa, all_fa, expg, 1'b0, 1, "arb111");
        end

        for (int v = 0; v < 8; v++) begin
            set_req(int'(vecs[v].id), vecs[v].cmd, vecs[v].arg, vecs[v].has_arg);
            grant(3'b001 << vecs[v].id, 1'b1, vecs[v].id, $sformatf("vec%0d", v));
            service(vecs[v].cmd, vecs[v].arg, vecs[v].has_arg, vecs[v].pc, vecs[v].pa,
                    vecs[v].id, vecs[v].exp_err, vecs[v].exp_sends, $sformatf("vec%0d", v));
        end

        set_req(0, 8'h11, 8'h22, 1'b1);
        grant(3'b001, 1'b1, 2'd0, "rst_mid");
        wait_cmd(8'h11, "rst_mid", f);
        perform(A_FA);
        wait_cmd(8'h22, "rst_mid", f);
        do_ack(1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(!ifc.busy && !ifc.command_valid, "rst_mid idle", 32'({ifc.busy, ifc.command_valid}), 32'd0);
        acc = 1'b0;
        repeat (24) begin
            @(negedge clk);
            acc = acc | ifc.done_valid | ifc.command_valid | ifc.busy;
        end
        check(!acc, "rst_mid quiet", 32'(acc), 32'd0);
        set_req(0, 8'h5A, 8'h00, 1'b0);
        grant(3'b011, 1'b1, 2'd0, "rst_after");
        service(8'h5A, 8'h00, 1'b0, all_fa, all_fa, 2'd0, 1'b0, 1, "rst_after");

        do_reset();
        last = 2'd2;
        for (int it = 0; it < 30; it++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                rc[i] = 8'($urandom);
                ra[i] = 8'($urandom);
                rh[i] = 1'($urandom_range(0, 1));
                set_req(i, rc[i], ra[i], rh[i]);
            end
            expg = last;
            for (int k = 1; k <= 3; k++) begin
                if (mask[(int'(last) + k) % 3]) begin
                    expg = 2'((int'(last) + k) % 3);
                    break;
                end
            end
            for (int i = 0; i < 4; i++) begin
                pc[i] = rnd_act(i == 3);
                pa[i] = rnd_act(i == 3);
            end
            nc = phase_sends(pc, okc);
            na = phase_sends(pa, oka);
            sends = nc + ((rh[expg] && okc) ? na : 0);
            grant(mask, 1'b1, expg, $sformatf("rnd%0d", it));
            service(rc[expg], ra[expg], rh[expg], pc, pa, expg,
                    !okc || (rh[expg] && !oka), sends, $sformatf("rnd%0d", it));
            last = expg;
        end

        check(mon_bad == 0, "req_ready_while_busy", 32'(mon_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_command_arbiter.md
PS2_COMMAND_ARBITER -- requirements
Module: ps2_command_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000, meaning wait-for-keyboard-response limit in clk cycles.
REQ-002 SHALL have parameter MAX_RETRIES, default 2'd3, meaning resend attempts per byte before error.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid / req_ready  input / output  3 / 3  per-requester command handshake; index 0 = init, 1 = LED status, 2 = misc.
REQ-006 SHALL have ports req_cmd, req_arg  input  3x8 each  command byte and optional argument byte per requester.
REQ-007 SHALL have port req_has_arg  input  3  requester's command carries an argument byte.
REQ-008 SHALL have ports command_valid / command_ready / command_byte  output / input / output  1 / 1 / 8  byte stream to the protocol layer.
REQ-009 SHALL have ports command_ack_valid / command_ack_ready / command_ack_error  input / output / input  1 / 1 / 1  transmit-complete status from the protocol layer.
REQ-010 SHALL have ports response_valid / response_byte  input / input  1 / 8  keyboard reply bytes; always accepted.
REQ-011 SHALL have ports done_valid, done_error, done_id  output  1, 1, 2  one-cycle completion pulse, failure flag, and served requester index.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SEND_CMD, TX_CMD, RESP_CMD, SEND_ARG, TX_ARG, RESP_ARG, DONE.
REQ-014 IDLE: when any req_valid is high, SHALL grant round-robin, searching from (last_grant+1) mod 3; SHALL assert req_ready[grant] for exactly that cycle, latch cmd/arg/has_arg/id, and go to SEND_CMD.
REQ-015 req_ready SHALL be zero in every state except the IDLE grant cycle.
REQ-016 SEND_CMD / SEND_ARG: SHALL drive command_valid=1 with the latched byte, held stable until command_ready; command_valid && command_ready moves to TX_CMD / TX_ARG.
REQ-017 TX_*: command_ack_ready SHALL be 1 only in TX_*; ack without error moves to RESP_*; ack with error counts as one retry.
REQ-018 RESP_*: timeout counter SHALL clear on entry and increment each cycle; response 8'hFA ends the phase; 8'hFE or counter reaching TIMEOUT_CYCLES-1 counts as one retry; any other byte is ignored.
REQ-019 Retry SHALL return to the same SEND_* state if retries < MAX_RETRIES, else go to DONE with error set; retry counter SHALL clear on each new byte.
REQ-020 FA in RESP_CMD SHALL go to SEND_ARG if has_arg, else DONE; FA in RESP_ARG SHALL go to DONE.
REQ-021 DONE: SHALL assert done_valid one cycle with done_id and done_error, update last_grant, return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-022 response_valid with FA and timeout expiry in the same cycle SHALL resolve as FA.
REQ-023 Requester deasserting req_valid after grant SHALL NOT abort the transaction.

Reset
REQ-024 Reset SHALL force IDLE, command_valid=0, command_ack_ready=0, req_ready=0, done_valid=0, done_error=0, done_id=0, busy=0, counters=0, last_grant=2 (requester 0 wins first).
REQ-025 Reset mid-transaction SHALL abandon it without a done pulse; next cycle after reset release SHALL be IDLE.

Structure
REQ-026 ps2_pkg SHALL hold the state enum and constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
REQ-027 Round-robin selection SHALL be a sub-module ps2_round_robin (3 requests, last_grant in, one-hot grant out, combinational).
REQ-028 Parameters SHALL remain overridable so benches use TIMEOUT_CYCLES=16.

Verification
REQ-029 req 1 ED/arg 02, protocol acks, responses FA, FA -> bytes ED then 02 on command_byte, done_id=1, done_error=0.
REQ-030 req 0 and 2 valid simultaneously after reset -> 0 served first, then 2; with all three held, order 0,1,2,0.
REQ-031 req 2 F4 no arg, responses FE, FE, FA -> F4 sent three times, done_error=0.
REQ-032 req 0 FF, no response, TIMEOUT_CYCLES=16 -> FF sent 4 times, done_error=1 after fourth timeout.
REQ-033 command_ack_error on arg byte once, then FA -> arg byte resent once, done_error=0.
REQ-034 reset asserted in RESP_ARG -> busy=0, no done_valid, next request granted normally.
